pipe_stage_skid: RTL and testbench

//  Parametrised ready/valid pipeline stage register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_pkg.sv | 40 ++++
 rtl/pipe_stage_skid_entry.sv | 56 +++++
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage boundary registers.
// Payload layout (identical at ID/EX, EX/MEM, MEM/WB; unused fields stay zero), occupancy encodings
// and the default NOP payload. An all-zero instruction word decodes as sll $0,$0,0, i.e. a nop.
package pipe_pkg;

    localparam int WORD_W    = 32;
    localparam int CTRL_W    = 16;
    localparam int N_WORDS   = 10;
    localparam int PAYLOAD_W = WORD_W * N_WORDS + CTRL_W;

    // Word slots within the packed payload, LSB first.
    localparam int OFF_IR    = 0 * WORD_W;
    localparam int OFF_A1    = 1 * WORD_W;
    localparam int OFF_A2    = 2 * WORD_W;
    localparam int OFF_A3    = 3 * WORD_W;
    localparam int OFF_V1    = 4 * WORD_W;
    localparam int OFF_V2    = 5 * WORD_W;
    localparam int OFF_EXT_S = 6 * WORD_W;
    localparam int OFF_EXT_Z = 7 * WORD_W;
    localparam int OFF_EXT_U = 8 * WORD_W;
    localparam int OFF_PCP4  = 9 * WORD_W;
    localparam int OFF_CTRL  = N_WORDS * WORD_W;

    // All-zero IR is the architectural nop; every other field zero as well.
    localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // skid can only be valid while main is valid, so main_v/skid_v map directly to a count.
    function automatic occ_e occ_encode(input logic main_v, input logic skid_v);
        if (skid_v)      return OCC_TWO;
        else if (main_v) return OCC_ONE;
        else             return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// pipe_entry: one valid+data+away holding register for the stage.
// Latency: loaded value visible the cycle after ld_i. Backpressure: none, caller decides load/clear.
// Ports: clk_i, rst_i (sync, active-high), clr_i, ld_i/ld_dat_i/ld_away_i in; vld_o/dat_o/away_o out.
module pipe_entry #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   NOP_VALUE = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_dat_i,
    input  logic         ld_away_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic         away_o
);

    logic         vld_q,  vld_d;
    logic [W-1:0] dat_q,  dat_d;
    logic         away_q, away_d;

    // Clearing rewrites the data regs with the NOP pattern so an empty
    // slot always presents a decodable nop and a clean tag.
    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        away_d = away_q;
        if (clr_i) begin
            vld_d  = 1'b0;
            dat_d  = NOP_VALUE;
            away_d = 1'b0;
        end else if (ld_i) begin
            vld_d  = 1'b1;
            dat_d  = ld_dat_i;
            away_d = ld_away_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            dat_q  <= NOP_VALUE;
            away_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            away_q <= away_d;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign away_o = away_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: ready/valid stage register with 2-entry skid, flush-to-NOP, exception tag, bubble counter.
// Latency: 1 cycle, full throughput. Backpressure: in_ready drops the cycle after the skid slot fills.
// Ports: CLK, reset, flush; in_valid/in_ready/in_data/in_away; out_valid/out_ready/out_data/out_away;
//        occupancy (0..2), bubble_cnt (saturating count of cycles with out_valid low).
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int           W         = PAYLOAD_W,
    parameter logic [W-1:0] NOP_VALUE = '0,
    parameter int           CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_away,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_away,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic         main_v, skid_v;
    logic [W-1:0] main_dat, skid_dat;
    logic         main_away, skid_away;

    logic         acc, pop, kill;
    logic         main_ld, main_clr, main_from_skid;
    logic         skid_ld, skid_clr;
    logic [W-1:0] main_ld_dat;
    logic         main_ld_away;

    logic [CNT_W-1:0] bubble_q, bubble_d;

    // in_ready is purely a function of held state and the kill inputs so
    // upstream can compute its own valid without a combinational loop.
    assign in_ready = !skid_v && !flush && !reset;
    assign acc      = in_valid && in_ready;
    assign pop      = main_v && out_ready;
    assign kill     = flush || reset;

    always_comb begin
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (kill) begin
            // Any handshake in flight this edge is discarded.
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!main_v) begin
            main_ld = acc;
        end else if (!skid_v) begin
            if (pop && acc)       main_ld  = 1'b1;
            else if (pop)         main_clr = 1'b1;
            else if (acc)         skid_ld  = 1'b1;
        end else if (pop) begin
            // Full: in_ready is low, so only the skid entry can move up.
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
        end
    end

    assign main_ld_dat  = main_from_skid ? skid_dat  : in_data;
    assign main_ld_away = main_from_skid ? skid_away : in_away;

    pipe_entry #(
        .W         (W),
        .NOP_VALUE (NOP_VALUE)
    ) u_main (
        .clk_i     (CLK),
        .rst_i     (reset),
        .clr_i     (main_clr),
        .ld_i      (main_ld),
        .ld_dat_i  (main_ld_dat),
        .ld_away_i (main_ld_away),
        .vld_o     (main_v),
        .dat_o     (main_dat),
        .away_o    (main_away)
    );

    pipe_entry #(
        .W         (W),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .clk_i     (CLK),
        .rst_i     (reset),
        .clr_i     (skid_clr),
        .ld_i      (skid_ld),
        .ld_dat_i  (in_data),
        .ld_away_i (in_away),
        .vld_o     (skid_v),
        .dat_o     (skid_dat),
        .away_o    (skid_away)
    );

    // Counts edges at which the stage had nothing to present; flush does
    // not reset it so it reflects flush-induced bubbles too.
    always_comb begin
        bubble_d = bubble_q;
        if (!main_v && (bubble_q != CNT_MAX)) bubble_d = bubble_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset) bubble_q <= '0;
        else       bubble_q <= bubble_d;
    end

    assign out_valid  = main_v;
    assign out_data   = main_dat;
    assign out_away   = main_away;
    assign occupancy  = occ_encode(main_v, skid_v);
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_pipe_stage_skid;

    localparam int           W     = 16;
    localparam int           CNT_W = 4;
    localparam logic [W-1:0] NOP   = 16'hDEAD;
    localparam int           CMAX  = (1 << CNT_W) - 1;

    logic             CLK;
    logic             reset, flush;
    logic             in_valid, in_ready, in_away;
    logic [W-1:0]     in_data;
    logic             out_valid, out_ready, out_away;
    logic [W-1:0]     out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_skid #(
        .W         (W),
        .NOP_VALUE (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_away    (in_away),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_away   (out_away),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two (data, away)
    // entries; everything observable follows from its contents.
    typedef struct packed {
        logic [W-1:0] d;
        logic         a;
    } ent_t;

    ent_t q[$];
    int   m_bub = 0;

    always @(posedge CLK) begin
        logic m_rdy, m_acc, m_pop;
        m_rdy = (q.size() < 2) && !flush && !reset;
        m_acc = in_valid && m_rdy;
        m_pop = (q.size() > 0) && out_ready;
        if (reset)                       m_bub = 0;
        else if (q.size() == 0 && m_bub < CMAX) m_bub = m_bub + 1;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back('{d: in_data, a: in_away});
        end
    end

    always @(negedge CLK) begin
        logic         e_v;
        logic [W-1:0] e_d;
        logic         e_a;
        e_v = q.size() > 0;
        e_d = e_v ? q[0].d : NOP;
        e_a = e_v ? q[0].a : 1'b0;
        check("m_out_valid", 32'(out_valid),  32'(e_v));
        check("m_out_data",  32'(out_data),   32'(e_d));
        check("m_out_away",  32'(out_away),   32'(e_a));
        check("m_occupancy", 32'(occupancy),  32'(q.size()));
        check("m_in_ready",  32'(in_ready),   32'((q.size() < 2) && !flush && !reset));
        check("m_bubble",    32'(bubble_cnt), 32'(m_bub));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic a, input logic r);
        in_valid  = v;
        in_data   = d;
        in_away   = a;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 16'h0055, 1'b1, 1'b0);

        // 1: reset held two cycles with in_valid high
        tick();
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_data",  32'(out_data),   32'hDEAD);
        check("rst_in_ready",  32'(in_ready),   32'd0);
        check("rst_occ",       32'(occupancy),  32'd0);
        check("rst_bubble",    32'(bubble_cnt), 32'd0);
        tick();
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        #1;
        check("rst_in_ready_rel", 32'(in_ready), 32'd1);
        tick();

        // 2: streaming 1..8 with out_ready high
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 16'(k), 1'b0, 1'b1);
            tick();
            check("strm_data",  32'(out_data),  32'(k));
            check("strm_occ",   32'(occupancy), 32'd1);
            check("strm_valid", 32'(out_valid), 32'd1);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("strm_drain_data", 32'(out_data), 32'hDEAD);

        // 3: backpressure 1,2,3
        drive(1'b1, 16'd1, 1'b0, 1'b0);
        tick();
        check("bp_occ1", 32'(occupancy), 32'd1);
        drive(1'b1, 16'd2, 1'b0, 1'b0);
        tick();
        check("bp_occ2",   32'(occupancy), 32'd2);
        check("bp_rdy_lo", 32'(in_ready),  32'd0);
        drive(1'b1, 16'd3, 1'b0, 1'b0);
        tick();
        check("bp_hold_occ",  32'(occupancy), 32'd2);
        check("bp_hold_data", 32'(out_data),  32'd1);
        drive(1'b1, 16'd3, 1'b0, 1'b1);
        tick();
        check("bp_rel_2", 32'(out_data), 32'd2);
        tick();
        check("bp_rel_3", 32'(out_data),  32'd3);
        check("bp_occ_3", 32'(occupancy), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // 4: flush at occupancy 2 with a beat (9) offered
        drive(1'b1, 16'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd6, 1'b0, 1'b0);
        tick();
        check("fl_pre_occ", 32'(occupancy), 32'd2);
        flush = 1'b1;
        drive(1'b1, 16'd9, 1'b1, 1'b1);
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("fl_occ",   32'(occupancy), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_data",  32'(out_data),  32'hDEAD);
        check("fl_away",  32'(out_away),  32'd0);
        tick();

        // 5: away tag travels with its beat through a stall
        drive(1'b1, 16'h00A1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h00B2, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        check("aw_A_data", 32'(out_data), 32'h00A1);
        check("aw_A_away", 32'(out_away), 32'd1);
        tick();
        check("aw_B_data", 32'(out_data), 32'h00B2);
        check("aw_B_away", 32'(out_away), 32'd0);
        tick();

        // 6: bubble counter saturation, then reset with two entries held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("bub_zero", 32'(bubble_cnt), 32'd0);
        tick();
        check("bub_one", 32'(bubble_cnt), 32'd1);
        for (int i = 0; i < 19; i++) tick();
        check("bub_sat", 32'(bubble_cnt), 32'd15);
        drive(1'b1, 16'd7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd8, 1'b1, 1'b0);
        tick();
        check("mr_occ2", 32'(occupancy), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("mr_occ",    32'(occupancy),  32'd0);
        check("mr_valid",  32'(out_valid),  32'd0);
        check("mr_data",   32'(out_data),   32'hDEAD);
        check("mr_away",   32'(out_away),   32'd0);
        check("mr_bubble", 32'(bubble_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 127) == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
